// File: rtl/lcf_pkg.sv
// rtl/lcf_pkg.sv - shared types and helpers for the latch pair capture block
package lcf_pkg;

    localparam int LCF_DATA_W = 8;

    typedef logic [2*LCF_DATA_W-1:0] pair_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lcf_fifo.sv
// rtl/lcf_fifo.sv - show-ahead synchronous FIFO with separate occupancy counter
module lcf_fifo
    import lcf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [W-1:0]              i_wdata,
    output logic [W-1:0]              o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [lvl_w(DEPTH)-1:0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          pop_ok;

    assign o_empty = (level_q == '0);
    assign o_full  = (level_q == LW'(DEPTH));
    assign o_level = level_q;
    assign pop_ok  = i_pop & ~o_empty;

    // Head is driven straight from storage so a word is visible as soon as it lands.
    assign o_rdata = o_empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({i_push, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/latch_pair_capture.sv
// rtl/latch_pair_capture.sv - samples the latch pair on window close and queues words
module latch_pair_capture
    import lcf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = LCF_DATA_W
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      en,
    input  logic [DATA_W-1:0]         i_a,
    input  logic [DATA_W-1:0]         i_b,
    output logic [2*DATA_W-1:0]       o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [lvl_w(DEPTH)-1:0]   o_level,
    output logic                      o_ovf,
    input  logic                      i_ovf_clr
);

    logic en_q, en_d;
    logic ovf_q, ovf_d;
    logic cap, push, pop, full, empty;

    // First low cycle after the window: latches are closed and their outputs stable.
    assign cap     = en_q & ~en;
    assign o_valid = ~empty;
    assign pop     = o_valid & i_ready;
    assign push    = cap & (~full | pop);
    assign o_ovf   = ovf_q;

    always_comb begin
        en_d  = en;
        ovf_d = ovf_q;
        if (i_ovf_clr) ovf_d = 1'b0;
        if (cap & full & ~pop) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) en_q <= 1'b0;
        else        en_q <= en_d;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    lcf_fifo #(
        .DEPTH (DEPTH),
        .W     (2*DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata ({i_a, i_b}),
        .o_rdata (o_data),
        .o_full  (full),
        .o_empty (empty),
        .o_level (o_level)
    );

endmodule

// File: tb/tb_latch_pair_capture.sv
// tb/tb_latch_pair_capture.sv - directed self-checking bench for latch_pair_capture
module tb_latch_pair_capture;
    import lcf_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int LW    = lvl_w(DEPTH);

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          en;
    logic [DW-1:0] i_a, i_b;
    logic [2*DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [LW-1:0] o_level;
    logic          o_ovf;
    logic          i_ovf_clr;

    int checks   = 0;
    int failures = 0;

    pair_t mq[$];
    int    delivered = 0;
    int    dropped   = 0;
    bit    en_prev   = 1'b0;

    always #5 i_clk = ~i_clk;

    latch_pair_capture #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .i_clk     (i_clk),
        .i_arst    (i_arst),
        .en        (en),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_level   (o_level),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic window(input logic [7:0] a, input logic [7:0] b);
        en = 1'b1;
        tick();
        en = 1'b0;
        i_a = a;
        i_b = b;
        tick();
    endtask

    task automatic model_step();
        bit pop_m;
        check("sb_valid", o_valid, mq.size() != 0);
        if (mq.size() != 0) check("sb_data", o_data, mq[0]);
        pop_m = (mq.size() != 0) && i_ready;
        if (pop_m) begin
            void'(mq.pop_front());
            delivered++;
        end
        if (en_prev && !en) begin
            if (mq.size() < DEPTH) mq.push_back({i_a, i_b});
            else                   dropped++;
        end
        en_prev = en;
        tick();
    endtask

    initial begin
        logic [15:0] exp4 [4];

        // 1: reset and idle with en low
        i_arst = 1'b1; en = 1'b0; i_a = '0; i_b = '0; i_ready = 1'b0; i_ovf_clr = 1'b0;
        tick(); tick();
        check("rst_valid", o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_ovf",   o_ovf,   0);
        check("rst_data",  o_data,  0);
        i_arst = 1'b0;
        repeat (5) tick();
        check("idle_valid", o_valid, 0);
        check("idle_level", o_level, 0);

        // 2: single window, consumer ready
        i_a = 8'hA5; i_b = 8'h3C; i_ready = 1'b1; en = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        tick();
        check("one_valid", o_valid, 1);
        check("one_data",  o_data,  16'hA53C);
        check("one_level", o_level, 1);
        tick();
        check("one_drained_level", o_level, 0);
        check("one_drained_valid", o_valid, 0);

        // 3: fill past capacity, then drain and clear overflow
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            window(8'(k), 8'hF0);
            if (k == 4) begin
                check("fill_level4", o_level, 4);
                check("fill_ovf4",   o_ovf,   0);
            end
        end
        check("ovf_level", o_level, 4);
        check("ovf_set",   o_ovf,   1);
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_data", o_data, {8'(k), 8'hF0});
            tick();
        end
        i_ready = 1'b0;
        check("drain_valid", o_valid, 0);
        check("drain_level", o_level, 0);
        check("ovf_sticky",  o_ovf,   1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        check("ovf_clr", o_ovf, 0);

        // 4: full FIFO, capture coincides with pop
        for (int k = 0; k < 4; k++) window(8'(8'h10 + k), 8'h11);
        check("full_level", o_level, 4);
        en = 1'b1;
        tick();
        en = 1'b0; i_a = 8'h20; i_b = 8'h11; i_ready = 1'b1;
        tick();
        check("pp_level", o_level, 4);
        check("pp_ovf",   o_ovf,   0);
        exp4[0] = 16'h1111; exp4[1] = 16'h1211; exp4[2] = 16'h1311; exp4[3] = 16'h2011;
        for (int k = 0; k < 4; k++) begin
            check("pp_data", o_data, exp4[k]);
            tick();
        end
        check("pp_empty", o_valid, 0);
        i_ready = 1'b0;

        // 5: reset mid-window with words queued
        window(8'h50, 8'h55);
        window(8'h51, 8'h55);
        check("pre_rst_level", o_level, 2);
        en = 1'b1;
        tick();
        i_arst = 1'b1;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_level", o_level, 0);
        check("arst_data",  o_data,  0);
        tick();
        i_arst = 1'b0;
        tick();
        en = 1'b0; i_a = 8'h77; i_b = 8'h88;
        tick();
        check("post_rst_level", o_level, 1);
        check("post_rst_data",  o_data,  16'h7788);
        repeat (3) tick();
        check("post_rst_single", o_level, 1);
        i_ready = 1'b1;
        tick();
        check("post_rst_drain", o_level, 0);
        i_ready = 1'b0;

        // 6: en toggling every cycle, random consumer, scoreboard
        en_prev = 1'b0;
        for (int w = 0; w < 12; w++) begin
            for (int ph = 0; ph < 2; ph++) begin
                en = (ph == 0);
                if (ph == 1) begin
                    i_a = 8'(8'h30 + w);
                    i_b = 8'(~w);
                end
                i_ready = 1'($urandom_range(0, 1));
                model_step();
            end
        end
        en = 1'b0;
        i_ready = 1'b1;
        repeat (6) model_step();
        check("sb_total", delivered + dropped, 12);
        check("sb_left",  mq.size(), 0);
        check("sb_level", o_level, 0);
        check("sb_ovf",   o_ovf, dropped > 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
